// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  mem_port_arbiter
//  Round-robin arbiter sharing one physical memory port between I and D sides.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_SERVE_I = 2'd1;
  localparam logic [1:0] c_ST_SERVE_D = 2'd2;
  localparam logic       c_GRANT_I    = 1'b0;
  localparam logic       c_GRANT_D    = 1'b1;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_last_grant;
  logic              r_op_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              w_d_req;
  logic              w_grant_d;

  assign w_d_req   = d_read | d_write;
  // Data side wins when alone, or in a conflict when instruction side went last.
  assign w_grant_d = w_d_req & (~i_read | (r_last_grant == c_GRANT_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_last_grant <= c_GRANT_I;
      r_op_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == c_ST_IDLE) begin
        if (w_grant_d) begin
          r_op_write <= d_write;
          r_addr     <= d_address;
          r_wdata    <= d_wdata;
        end else if (i_read) begin
          r_op_write <= 1'b0;
          r_addr     <= i_address;
          r_wdata    <= '0;
        end
      end else if (pmem_resp) begin
        r_last_grant <= (r_state == c_ST_SERVE_D) ? c_GRANT_D : c_GRANT_I;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_grant_d)   w_next_state = c_ST_SERVE_D;
        else if (i_read) w_next_state = c_ST_SERVE_I;
      end
      c_ST_SERVE_I,
      c_ST_SERVE_D: begin
        if (pmem_resp) w_next_state = c_ST_IDLE;
      end
      default: w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (r_state)
      c_ST_SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = r_addr;
        pmem_wdata   = r_wdata;
        i_resp       = pmem_resp;
      end
      c_ST_SERVE_D: begin
        pmem_read    = ~r_op_write;
        pmem_write   = r_op_write;
        pmem_address = r_addr;
        pmem_wdata   = r_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  tb_mem_port_arbiter
//  Directed bench for mem_port_arbiter against a transaction-level model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam logic [LINE_W-1:0] c_A5    = {16{8'hA5}};
  localparam logic [LINE_W-1:0] c_WDATA = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp = 1'b0;
  logic [LINE_W-1:0] pmem_rdata = '0;

  int n_checks = 0;
  int n_err    = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding transaction, side 1=I, 2=D.
  bit                m_valid;
  int                m_side;
  bit                m_write;
  bit                m_last_d;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_side   <= 0;
      m_write  <= 1'b0;
      m_last_d <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else if (m_valid) begin
      if (pmem_resp) begin
        m_valid  <= 1'b0;
        m_last_d <= (m_side == 2);
      end
    end else if ((d_read || d_write) && (!i_read || !m_last_d)) begin
      m_valid <= 1'b1;
      m_side  <= 2;
      m_write <= d_write;
      m_addr  <= d_address;
      m_wdata <= d_wdata;
    end else if (i_read) begin
      m_valid <= 1'b1;
      m_side  <= 1;
      m_write <= 1'b0;
      m_addr  <= i_address;
      m_wdata <= '0;
    end
  end

  always @(negedge clk) begin
    chk("cmp pmem_read",  pmem_read,  m_valid && !m_write);
    chk("cmp pmem_write", pmem_write, m_valid && m_write);
    chk("cmp pmem_address", pmem_address, m_valid ? m_addr : '0);
    chk("cmp pmem_wdata", pmem_wdata, m_valid ? m_wdata : '0);
    chk("cmp i_resp", i_resp, m_valid && m_side == 1 && pmem_resp);
    chk("cmp d_resp", d_resp, m_valid && m_side == 2 && pmem_resp);
    chk("cmp i_rdata", i_rdata, pmem_rdata);
    chk("cmp d_rdata", d_rdata, pmem_rdata);
  end

  task automatic start_resp(input logic [LINE_W-1:0] data);
    @(posedge clk); #2;
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    #1;
  endtask

  task automatic end_resp();
    @(posedge clk); #2;
    pmem_resp = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset pmem_read", pmem_read, 1'b0);
    chk("reset pmem_write", pmem_write, 1'b0);
    chk("reset pmem_address", pmem_address, '0);
    chk("reset resp", {i_resp, d_resp}, 2'b00);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single instruction read
    @(posedge clk); #2;
    i_read = 1'b1; i_address = 16'h1230;
    @(posedge clk); #3;
    chk("ird strobe", pmem_read, 1'b1);
    chk("ird addr", pmem_address, 16'h1230);
    @(posedge clk);
    start_resp(c_A5);
    chk("ird i_resp", i_resp, 1'b1);
    chk("ird i_rdata", i_rdata, c_A5);
    chk("ird d_resp", d_resp, 1'b0);
    end_resp();
    i_read = 1'b0;

    // Data write; requester address changes after grant
    @(posedge clk); #2;
    d_write = 1'b1; d_address = 16'h4000; d_wdata = c_WDATA;
    @(posedge clk); #2;
    d_address = 16'hFFFF; d_wdata = '1;
    #1;
    chk("dwr strobe", {pmem_read, pmem_write}, 2'b01);
    chk("dwr addr", pmem_address, 16'h4000);
    chk("dwr wdata", pmem_wdata, c_WDATA);
    start_resp('0);
    chk("dwr d_resp", d_resp, 1'b1);
    chk("dwr i_resp", i_resp, 1'b0);
    end_resp();
    d_write = 1'b0;

    // Post-reset conflicts alternate D then I, twice
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    for (int r = 0; r < 2; r++) begin
      i_read = 1'b1; i_address = 16'h1000;
      d_read = 1'b1; d_address = 16'h2000;
      @(posedge clk); #3;
      chk("conflict D first addr", pmem_address, 16'h2000);
      chk("conflict D first read", pmem_read, 1'b1);
      start_resp(128'h1);
      chk("conflict d_resp", {i_resp, d_resp}, 2'b01);
      end_resp();
      d_read = 1'b0;
      #3;
      chk("conflict idle gap", pmem_read, 1'b0);
      @(posedge clk); #3;
      chk("conflict I second addr", pmem_address, 16'h1000);
      start_resp(128'h2);
      chk("conflict i_resp", {i_resp, d_resp}, 2'b10);
      end_resp();
      i_read = 1'b0;
    end

    // Read/write collision serves a write
    @(posedge clk); #2;
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0040; d_wdata = c_WDATA;
    @(posedge clk); #3;
    chk("collision strobes", {pmem_read, pmem_write}, 2'b01);
    start_resp('0);
    chk("collision d_resp", d_resp, 1'b1);
    end_resp();
    d_read = 1'b0; d_write = 1'b0;

    // Reset in the middle of an instruction read
    @(posedge clk); #2;
    i_read = 1'b1; i_address = 16'h0BEE;
    @(posedge clk); #3;
    chk("midrst strobe before", pmem_read, 1'b1);
    #1;
    rst_n = 1'b0; pmem_resp = 1'b1;
    #1;
    chk("midrst strobe cleared", pmem_read, 1'b0);
    chk("midrst no i_resp", i_resp, 1'b0);
    @(posedge clk); #2;
    i_read = 1'b0; pmem_resp = 1'b0; rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    chk("midrst stays idle", {pmem_read, pmem_write}, 2'b00);

    // Spurious pmem_resp in IDLE
    @(posedge clk); #2;
    pmem_resp = 1'b1; pmem_rdata = c_A5;
    #1;
    chk("spurious resp", {i_resp, d_resp}, 2'b00);
    @(posedge clk); #2;
    pmem_resp = 1'b0;
    #1;
    chk("spurious stays idle", {pmem_read, pmem_write}, 2'b00);
    i_read = 1'b1; i_address = 16'h0777;
    @(posedge clk); #3;
    chk("after spurious serve", pmem_address, 16'h0777);
    start_resp(c_A5);
    chk("after spurious i_resp", i_resp, 1'b1);
    end_resp();
    i_read = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, physical address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache-line data width.
REQ-003 SHALL have ports (one per line below; reset is asynchronous, active-low):
  clk  in  1  single clock; all state updates on its rising edge
  rst_n  in  1  asynchronous active-low reset
  i_read  in  1  instruction-side line read request, level, held until i_resp
  i_address  in  ADDR_W  instruction-side line address
  i_resp  out  1  instruction-side completion, one cycle
  i_rdata  out  LINE_W  instruction-side read data, valid with i_resp
  d_read  in  1  data-side line read request, level, held until d_resp
  d_write  in  1  data-side line write request, level, held until d_resp
  d_address  in  ADDR_W  data-side line address
  d_wdata  in  LINE_W  data-side write data
  d_resp  out  1  data-side completion, one cycle
  d_rdata  out  LINE_W  data-side read data, valid with d_resp
  pmem_read  out  1  physical memory read strobe
  pmem_write  out  1  physical memory write strobe
  pmem_address  out  ADDR_W  physical memory address
  pmem_wdata  out  LINE_W  physical memory write data
  pmem_resp  in  1  physical memory completion, one cycle
  pmem_rdata  in  LINE_W  physical memory read data, valid with pmem_resp

Function
REQ-004 SHALL implement FSM with states IDLE, SERVE_I, SERVE_D.
REQ-005 SHALL, in IDLE, hold pmem_read=0 and pmem_write=0.
REQ-006 SHALL, in IDLE, go to SERVE_I next edge when only i_read=1.
REQ-007 SHALL, in IDLE, go to SERVE_D next edge when only (d_read|d_write)=1.
REQ-008 SHALL, in IDLE with both sides requesting, grant the side not granted last (round-robin via 1-bit last_grant).
REQ-009 SHALL stay in IDLE when no request is asserted.
REQ-010 SHALL, on the IDLE-exit edge, latch the granted side's address, operation, and (data side) d_wdata into internal registers.
REQ-011 SHALL drive pmem_address, pmem_wdata, pmem_read, and pmem_write only from the latched registers in SERVE_I/SERVE_D, so requester input changes after grant have no effect.
REQ-012 SHALL assert pmem_read in SERVE_I; in SERVE_D SHALL assert pmem_write if latched op is write, else pmem_read; never both.
REQ-013 SHALL, if d_read and d_write are both 1 at grant, latch write and serve a write.
REQ-014 SHALL remain in SERVE_x while pmem_resp=0; no timeout.
REQ-015 SHALL, in the cycle pmem_resp=1, combinationally assert the granted side's resp and pass pmem_rdata to its rdata; the other side's resp stays 0.
REQ-016 SHALL, on the edge ending a pmem_resp=1 cycle, return to IDLE and set last_grant to the served side.
REQ-017 SHALL, for minimum latency, take 1 cycle from request to pmem strobe and 1 IDLE cycle between back-to-back transactions.
REQ-018 SHALL ignore pmem_resp while in IDLE.
REQ-019 SHALL drive i_rdata/d_rdata to pmem_rdata unconditionally; only resp qualifies them.
REQ-020 Requesters SHALL deassert their request in the cycle after their resp; the arbiter does not filter stale requests.

Reset
REQ-021 SHALL, on rst_n=0, immediately and asynchronously enter IDLE, clear latched op/address/wdata to 0, and set last_grant=I (data side wins the first conflict).
REQ-022 SHALL, after reset, hold all outputs at 0: pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp.
REQ-023 SHALL, when reset occurs mid-transaction, abandon the transaction without generating a resp.

Verification
REQ-024 SHALL pass a single instruction read: i_read=1, i_address=0x1230; pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1, addr 0x1230 from cycle 1; i_resp=1 with i_rdata=0xA5..A5; d_resp=0.
REQ-025 SHALL pass a data write: d_write=1, d_address=0x4000, d_wdata=0x0123..EF; d_address changed to 0xFFFF after grant -> pmem_write=1, pmem_address stays 0x4000, pmem_wdata=0x0123..EF; d_resp on pmem_resp.
REQ-026 SHALL pass a post-reset conflict: i_read and d_read both held -> D served first, then I after one IDLE cycle; a second simultaneous pair -> D, then I again (alternation).
REQ-027 SHALL pass a read/write collision: d_read=d_write=1 -> only pmem_write asserted.
REQ-028 SHALL pass reset mid-op: rst_n low during SERVE_I before pmem_resp -> pmem_read=0 immediately, no i_resp; after release with no requests -> stays IDLE.
REQ-029 SHALL pass spurious resp: pmem_resp=1 in IDLE -> i_resp=d_resp=0, state unchanged.
